// File: rtl/seg7_pkg.sv
// ---------------------------------------------------------------------------
// seg7_pkg
// Shared constants for the seven-segment decoder slice:
//   SEG_OFF      - byte pattern that turns every segment and the dp dark
//   SEG_A..SEG_G - bit positions of the segments inside one digit byte
//   SEG_DP       - bit position of the decimal point inside one digit byte
//   FONT         - 16-entry hex font, active-low {g,f,e,d,c,b,a}
// ---------------------------------------------------------------------------
package seg7_pkg;

    localparam logic [7:0] SEG_OFF = 8'hFF;

    localparam int SEG_A  = 0;
    localparam int SEG_B  = 1;
    localparam int SEG_C  = 2;
    localparam int SEG_D  = 3;
    localparam int SEG_E  = 4;
    localparam int SEG_F  = 5;
    localparam int SEG_G  = 6;
    localparam int SEG_DP = 7;

    // A '0' bit lights the segment (common-anode display).
    localparam logic [6:0] FONT [16] = '{
        7'b1000000,  // 0
        7'b1111001,  // 1
        7'b0100100,  // 2
        7'b0110000,  // 3
        7'b0011001,  // 4
        7'b0010010,  // 5
        7'b0000010,  // 6
        7'b1111000,  // 7
        7'b0000000,  // 8
        7'b0010000,  // 9
        7'b0001000,  // A
        7'b0000011,  // b
        7'b1000110,  // C
        7'b0100001,  // d
        7'b0000110,  // E
        7'b0001110   // F
    };

endpackage

// File: rtl/seg7_font.sv
// ---------------------------------------------------------------------------
// seg7_font
// Purely combinational hex-nibble to seven-segment glyph lookup.
// Ports:
//   nibble - 4-bit hex value to display
//   seg_n  - active-low segment pattern {g,f,e,d,c,b,a}
// ---------------------------------------------------------------------------
module seg7_font
    import seg7_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg_n
);

    assign seg_n = FONT[nibble];

endmodule

// File: rtl/seg7_dec.sv
// ---------------------------------------------------------------------------
// seg7_dec
// Registered hex-to-seven-segment decoder for common-anode displays, with
// per-digit decimal point, global blanking and optional leading-zero
// blanking. Output is registered (1-cycle latency, no comb input path).
// Parameters:
//   DIGITS - number of digits decoded in parallel (1..8)
//   LZB_EN - 1 builds the leading-zero blanking logic, 0 ignores LZB
// Ports:
//   CLK   - clock, rising edge
//   nRST  - asynchronous active-low reset, forces nHEX dark
//   DIN   - hex nibbles, digit k at DIN[4k+3:4k]
//   DP    - decimal-point request per digit, active-high
//   BLANK - forces every segment and dp off
//   LZB   - leading-zero blanking request (only when LZB_EN=1)
//   nHEX  - active-low segments, digit k at nHEX[8k+7:8k], {dp,g..a}
// ---------------------------------------------------------------------------
module seg7_dec
    import seg7_pkg::*;
#(
    parameter int DIGITS = 1,
    parameter int LZB_EN = 0
) (
    input  logic                  CLK,
    input  logic                  nRST,
    input  logic [4*DIGITS-1:0]   DIN,
    input  logic [DIGITS-1:0]     DP,
    input  logic                  BLANK,
    input  logic                  LZB,
    output logic [8*DIGITS-1:0]   nHEX
);

    localparam bit LZB_PRESENT = (LZB_EN != 0);

    logic [6:0]          font_n [DIGITS];
    logic [DIGITS-1:0]   lz_blank;
    logic                lzb_active;
    logic                still_leading;
    logic [8*DIGITS-1:0] nhex_d;
    logic [8*DIGITS-1:0] nhex_q;

    for (genvar k = 0; k < DIGITS; k++) begin : g_font
        seg7_font u_font (
            .nibble (DIN[4*k +: 4]),
            .seg_n  (font_n[k])
        );
    end

    assign lzb_active = LZB_PRESENT && LZB;

    // Walk from the most significant digit down; zeros stay blanked until
    // the first non-zero digit. Digit 0 is excluded so a value of zero
    // still shows a single "0".
    always_comb begin
        lz_blank      = '0;
        still_leading = lzb_active;
        for (int k = DIGITS - 1; k >= 1; k--) begin
            if (still_leading && (DIN[4*k +: 4] == 4'h0)) begin
                lz_blank[k] = 1'b1;
            end else begin
                still_leading = 1'b0;
            end
        end
    end

    // A blanked digit (BLANK or leading zero) also drops its dp.
    always_comb begin
        nhex_d = '1;
        for (int k = 0; k < DIGITS; k++) begin
            if (BLANK || lz_blank[k]) begin
                nhex_d[8*k +: 8] = SEG_OFF;
            end else begin
                nhex_d[8*k + SEG_DP]   = ~DP[k];
                nhex_d[8*k + SEG_A +: 7] = font_n[k];
            end
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            nhex_q <= '1;
        end else begin
            nhex_q <= nhex_d;
        end
    end

    assign nHEX = nhex_q;

endmodule

// File: tb/tb_seg7_dec.sv
// ---------------------------------------------------------------------------
// tb_seg7_dec
// Drives a single-digit decoder and a four-digit decoder with leading-zero
// blanking side by side. Expected bytes are hand-written; a scoreboard
// queue is filled by the stimulus task and drained by a monitor process.
// ---------------------------------------------------------------------------
module tb_seg7_dec;

    typedef struct {
        logic [7:0]  exp1;
        logic [31:0] exp4;
        string       name;
    } sb_entry_t;

    logic        clk;
    logic        n_rst;
    logic [3:0]  din1;
    logic [0:0]  dp1;
    logic [15:0] din4;
    logic [3:0]  dp4;
    logic        blank;
    logic        lzb;
    logic [7:0]  nhex1;
    logic [31:0] nhex4;

    sb_entry_t   sb_q [$];
    int          vectors;
    int          miscompares;

    logic [7:0]  font_table [16] = '{
        8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
        8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E
    };

    seg7_dec #(.DIGITS(1), .LZB_EN(0)) dut1 (
        .CLK   (clk),
        .nRST  (n_rst),
        .DIN   (din1),
        .DP    (dp1),
        .BLANK (blank),
        .LZB   (lzb),
        .nHEX  (nhex1)
    );

    seg7_dec #(.DIGITS(4), .LZB_EN(1)) dut4 (
        .CLK   (clk),
        .nRST  (n_rst),
        .DIN   (din4),
        .DP    (dp4),
        .BLANK (blank),
        .LZB   (lzb),
        .nHEX  (nhex4)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    // Drive one input set on the falling edge; the result is due right
    // after the following rising edge.
    task automatic applyStimulus(input string name,
                                 input logic [3:0] d1, input logic p1,
                                 input logic [15:0] d4, input logic [3:0] p4,
                                 input logic b, input logic l,
                                 input logic [7:0] e1, input logic [31:0] e4);
        sb_entry_t ent;
        @(negedge clk);
        din1  = d1;
        dp1   = p1;
        din4  = d4;
        dp4   = p4;
        blank = b;
        lzb   = l;
        ent.exp1 = e1;
        ent.exp4 = e4;
        ent.name = name;
        sb_q.push_back(ent);
    endtask

    // Monitor: the decoder presents a new value after every rising edge.
    initial begin
        sb_entry_t ent;
        forever begin
            @(posedge clk);
            #1;
            if (n_rst && sb_q.size() > 0) begin
                ent = sb_q.pop_front();
                checkOutput({ent.name, "_d1"}, {24'h0, nhex1}, {24'h0, ent.exp1});
                checkOutput({ent.name, "_d4"}, nhex4, ent.exp4);
            end
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        vectors     = 0;
        miscompares = 0;
        n_rst = 1'b1;
        din1  = 4'h8;
        dp1   = 1'b0;
        din4  = 16'h8888;
        dp4   = 4'h0;
        blank = 1'b0;
        lzb   = 1'b0;

        // Reset asserted between edges must darken the outputs at once.
        #1;
        n_rst = 1'b0;
        #1;
        checkOutput("reset_async_d1", {24'h0, nhex1}, 32'h0000_00FF);
        checkOutput("reset_async_d4", nhex4, 32'hFFFF_FFFF);
        @(posedge clk);
        #2;
        checkOutput("reset_held_d1", {24'h0, nhex1}, 32'h0000_00FF);
        checkOutput("reset_held_d4", nhex4, 32'hFFFF_FFFF);
        @(negedge clk);
        n_rst = 1'b1;
        applyStimulus("reset_release", 4'h8, 1'b0, 16'h8888, 4'h0, 1'b0, 1'b0,
                      8'h80, 32'h8080_8080);

        // Full sweep including the F -> 0 wrap.
        for (int v = 0; v <= 16; v++) begin
            logic [3:0] nib;
            nib = v[3:0];
            applyStimulus("sweep", nib, 1'b0, {4{nib}}, 4'h0, 1'b0, 1'b0,
                          font_table[nib], {4{font_table[nib]}});
        end

        // Decimal point.
        applyStimulus("dp_on", 4'h5, 1'b1, 16'h0005, 4'b0001, 1'b0, 1'b0,
                      8'h12, 32'hC0C0_C012);
        applyStimulus("dp_off", 4'h5, 1'b0, 16'h0005, 4'b0000, 1'b0, 1'b0,
                      8'h92, 32'hC0C0_C092);

        // Global blanking overrides everything including dp.
        applyStimulus("blank_on", 4'h3, 1'b1, 16'h1234, 4'hF, 1'b1, 1'b1,
                      8'hFF, 32'hFFFF_FFFF);
        applyStimulus("blank_off", 4'h3, 1'b0, 16'h1234, 4'h0, 1'b0, 1'b0,
                      8'hB0, 32'hF9A4_B099);

        // Leading-zero blanking on the four-digit instance.
        applyStimulus("lzb_0070", 4'h0, 1'b0, 16'h0070, 4'h0, 1'b0, 1'b1,
                      8'hC0, 32'hFFFF_F8C0);
        applyStimulus("lzb_0000", 4'h0, 1'b0, 16'h0000, 4'h0, 1'b0, 1'b1,
                      8'hC0, 32'hFFFF_FFC0);
        applyStimulus("lzb_1000", 4'h1, 1'b0, 16'h1000, 4'h0, 1'b0, 1'b1,
                      8'hF9, 32'hF9C0_C0C0);
        applyStimulus("lzb_0203", 4'h2, 1'b0, 16'h0203, 4'h0, 1'b0, 1'b1,
                      8'hA4, 32'hFFA4_C0B0);
        applyStimulus("lzb_dp", 4'h5, 1'b1, 16'h0005, 4'hF, 1'b0, 1'b1,
                      8'h12, 32'hFFFF_FF12);
        applyStimulus("lzb_off", 4'h7, 1'b0, 16'h0070, 4'h0, 1'b0, 1'b0,
                      8'hF8, 32'hC0C0_F8C0);

        // Reset in the middle of a counting stream.
        for (int v = 0; v < 4; v++) begin
            logic [3:0] nib;
            nib = v[3:0];
            applyStimulus("count", nib, 1'b0, {4{nib}}, 4'h0, 1'b0, 1'b0,
                          font_table[nib], {4{font_table[nib]}});
        end
        @(posedge clk);
        #3;
        n_rst = 1'b0;
        #1;
        checkOutput("midreset_d1", {24'h0, nhex1}, 32'h0000_00FF);
        checkOutput("midreset_d4", nhex4, 32'hFFFF_FFFF);
        @(posedge clk);
        #2;
        checkOutput("midreset_held_d1", {24'h0, nhex1}, 32'h0000_00FF);
        checkOutput("midreset_held_d4", nhex4, 32'hFFFF_FFFF);
        #1;
        n_rst = 1'b1;
        for (int v = 4; v < 7; v++) begin
            logic [3:0] nib;
            nib = v[3:0];
            applyStimulus("resume", nib, 1'b0, {4{nib}}, 4'h0, 1'b0, 1'b0,
                          font_table[nib], {4{font_table[nib]}});
        end

        @(posedge clk);
        #3;
        checkOutput("sb_drained", sb_q.size(), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
